// File: rtl/lead_one_norm_pipe.sv
// Two-stage pipelined leading-one detector with optional left normaliser.
// Define LOD_NORM_EN to build the normalising shifter; otherwise out_norm is tied to 0.
module lead_one_norm_pipe #(
  parameter int WIDTH   = 16,
  parameter int MIN_POS = 8,
  parameter int POS_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_pos,
  output logic             out_found,
  output logic [WIDTH-1:0] out_norm
);

  logic             adv;
  logic             s1_valid;
  logic             s2_valid;
  logic [POS_W-1:0] enc_pos;
  logic             enc_found;
  logic [POS_W-1:0] s1_pos;
  logic             s1_found;
  logic [POS_W-1:0] s2_pos;
  logic             s2_found;

  // Both stages move together; a stalled, occupied output freezes the whole pipe.
  assign adv      = !s2_valid || out_ready;
  assign in_ready = adv;

  // Ascending scan so the highest set bit inside the window wins.
  always_comb begin
    enc_pos   = '0;
    enc_found = 1'b0;
    for (int i = MIN_POS; i < WIDTH; i++) begin
      if (in_data[i]) begin
        enc_pos   = POS_W'(i);
        enc_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_pos   <= '0;
      s1_found <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_pos   <= enc_pos;
      s1_found <= enc_found;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_pos   <= '0;
      s2_found <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_pos   <= s1_pos;
      s2_found <= s1_found;
    end
  end

  assign out_valid = s2_valid;
  assign out_pos   = s2_pos;
  assign out_found = s2_found;

`ifdef LOD_NORM_EN
  localparam logic [POS_W-1:0] TOP_POS = POS_W'(WIDTH - 1);

  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] norm_next;
  logic [WIDTH-1:0] s2_norm;
  logic [POS_W-1:0] shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data <= '0;
    end else if (adv) begin
      s1_data <= in_data;
    end
  end

  // Operands with no bit in the window pass through unshifted.
  always_comb begin
    shamt     = TOP_POS - s1_pos;
    norm_next = s1_found ? (s1_data << shamt) : s1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_norm <= '0;
    end else if (adv) begin
      s2_norm <= norm_next;
    end
  end

  assign out_norm = s2_norm;
`else
  logic unused_data;
  assign unused_data = ^in_data;
  assign out_norm    = '0;
`endif

endmodule

// File: tb/tb_lead_one_norm_pipe.sv
// Scoreboard bench for lead_one_norm_pipe: 16-bit/MIN_POS=8 instance plus a 32-bit/MIN_POS=0 instance.
module tb_lead_one_norm_pipe;

  typedef struct {
    logic [4:0]  pos;
    logic        found;
    logic [31:0] norm;
    int          exp_cycle;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_pos;
  logic        out_found;
  logic [15:0] out_norm;

  logic        in_valid32;
  logic        in_ready32;
  logic [31:0] in_data32;
  logic        out_valid32;
  logic        out_ready32;
  logic [4:0]  out_pos32;
  logic        out_found32;
  logic [31:0] out_norm32;

  exp_t q16[$];
  exp_t q32[$];
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  lead_one_norm_pipe #(.WIDTH(16), .MIN_POS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pos(out_pos), .out_found(out_found), .out_norm(out_norm)
  );

  lead_one_norm_pipe #(.WIDTH(32), .MIN_POS(0)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .out_pos(out_pos32), .out_found(out_found32), .out_norm(out_norm32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] norm_exp(input logic [31:0] v);
`ifdef LOD_NORM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Drives one operand at the negedge; expectation is queued only once it is actually accepted.
  task automatic apply_stimulus(input logic [15:0] data, input logic [3:0] pos, input logic found,
                                input logic [15:0] norm, input int delay);
    exp_t e;
    int   waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    #1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stuck at 0 for operand %h", data);
    end else begin
      e.pos       = 5'(pos);
      e.found     = found;
      e.norm      = norm_exp(32'(norm));
      e.exp_cycle = (delay < 0) ? -1 : cycle + delay;
      q16.push_back(e);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitors pop an expectation whenever the DUT retires a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (q16.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_out16: pos %0d with empty scoreboard", out_pos);
        end else begin
          e = q16.pop_front();
          check_output("out_pos", 32'(out_pos), 32'(e.pos));
          check_output("out_found", 32'(out_found), 32'(e.found));
          check_output("out_norm", 32'(out_norm), e.norm);
          if (e.exp_cycle >= 0) check_output("retire_cycle", 32'(cycle), 32'(e.exp_cycle));
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid32 && out_ready32) begin
        if (q32.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_out32: pos %0d with empty scoreboard", out_pos32);
        end else begin
          e = q32.pop_front();
          check_output("out_pos32", 32'(out_pos32), 32'(e.pos));
          check_output("out_found32", 32'(out_found32), 32'(e.found));
          check_output("out_norm32", out_norm32, e.norm);
          check_output("retire_cycle32", 32'(cycle), 32'(e.exp_cycle));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e32;
    int   waited;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    in_valid32  = 1'b0;
    in_data32   = '0;
    out_ready32 = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_pos", 32'(out_pos), 32'd0);
    check_output("rst_out_found", 32'(out_found), 32'd0);
    check_output("rst_out_norm", 32'(out_norm), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_output("idle_in_ready", 32'(in_ready), 32'd1);

    // Directed values, each retiring two cycles after its accept cycle.
    apply_stimulus(16'h8000, 4'd15, 1'b1, 16'h8000, 2);
    go_idle();
    apply_stimulus(16'h0100, 4'd8,  1'b1, 16'h8000, 2);
    go_idle();
    apply_stimulus(16'h0A30, 4'd11, 1'b1, 16'hA300, 2);
    go_idle();
    apply_stimulus(16'h00FF, 4'd0,  1'b0, 16'h00FF, 2);
    go_idle();
    apply_stimulus(16'h0000, 4'd0,  1'b0, 16'h0000, 2);
    go_idle();
    repeat (3) @(negedge clk);

    // Wider instance with the window reaching bit 0.
    @(negedge clk);
    in_valid32 = 1'b1;
    in_data32  = 32'h0000_0001;
    #1;
    e32.pos       = 5'd0;
    e32.found     = 1'b1;
    e32.norm      = norm_exp(32'h8000_0000);
    e32.exp_cycle = cycle + 2;
    q32.push_back(e32);
    @(negedge clk);
    in_valid32 = 1'b0;

    // Eight back-to-back operands; fixed latency implies consecutive retirement.
    apply_stimulus(16'h1234, 4'd12, 1'b1, 16'h91A0, 2);
    apply_stimulus(16'hFFFF, 4'd15, 1'b1, 16'hFFFF, 2);
    apply_stimulus(16'h0300, 4'd9,  1'b1, 16'hC000, 2);
    apply_stimulus(16'h7000, 4'd14, 1'b1, 16'hE000, 2);
    apply_stimulus(16'h00F0, 4'd0,  1'b0, 16'h00F0, 2);
    apply_stimulus(16'h0555, 4'd10, 1'b1, 16'hAAA0, 2);
    apply_stimulus(16'h2001, 4'd13, 1'b1, 16'h8004, 2);
    apply_stimulus(16'h0800, 4'd11, 1'b1, 16'h8000, 2);
    go_idle();
    repeat (3) @(negedge clk);

    // Backpressure: two operands then a three-cycle stall.
    apply_stimulus(16'h4000, 4'd14, 1'b1, 16'h8000, 5);
    apply_stimulus(16'h0200, 4'd9,  1'b1, 16'h8000, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check_output("stall_in_ready", 32'(in_ready), 32'd0);
      check_output("stall_out_valid", 32'(out_valid), 32'd1);
      check_output("stall_out_pos", 32'(out_pos), 32'd14);
    end
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset while an operand is stalled at the output.
    apply_stimulus(16'h4000, 4'd14, 1'b1, 16'h8000, -1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    check_output("prerst_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    q16.delete();
    check_output("midrst_out_valid", 32'(out_valid), 32'd0);
    check_output("midrst_out_pos", 32'(out_pos), 32'd0);
    check_output("midrst_out_found", 32'(out_found), 32'd0);
    check_output("midrst_out_norm", 32'(out_norm), 32'd0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    #1;
    check_output("postrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    apply_stimulus(16'h2000, 4'd13, 1'b1, 16'h8000, 2);
    go_idle();

    waited = 0;
    while ((q16.size() != 0 || q32.size() != 0) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q16.size() != 0 || q32.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d/%0d results never retired, expected 0", q16.size(), q32.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lead_one_norm_pipe.md
# lead_one_norm_pipe

Parametrised, pipelined leading-one detector and normaliser for the compensated divider datapath. It accepts a WIDTH-bit operand under a valid/ready handshake and reports the bit position of the highest set bit inside a programmable search window. It also reports whether any bit was found, plus an optional left-normalised copy of the operand. It sits between the operand register and the divider's reciprocal-lookup / shift stage.

## Interface
- WIDTH, 16, operand width in bits; must be ≥ 2.
- MIN_POS, 8, lowest bit index searched; bits below MIN_POS are ignored for detection; 0 ≤ MIN_POS ≤ WIDTH-1.
- POS_W, $clog2(WIDTH), width of the position output (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand present on in_data.
- in_ready  out  1  block accepts the operand this cycle.
- in_data  in  WIDTH  operand.
- out_valid  out  1  result present on the out_* buses.
- out_ready  in  1  consumer accepts the result this cycle.
- out_pos  out  POS_W  index of the highest set bit in in_data[WIDTH-1:MIN_POS]; 0 when none.
- out_found  out  1  1 if any bit in the window was set.
- out_norm  out  WIDTH  normalised operand (see Configuration).

## Operation
- Two register stages, S1 and S2. Each stage holds a valid bit and its data. S2 drives the out_* ports.
- Global advance: adv = !out_valid | out_ready. Both stages load on adv and hold otherwise.
- in_ready = adv, combinational. A transfer occurs when in_valid & in_ready. Output retirement occurs when out_valid & out_ready.
- S1 loads in_data and the valid bit (in_valid & adv). It computes the priority encode: scan from bit WIDTH-1 down to MIN_POS, and the first 1 gives pos.
- S1 registers pos, found and the raw operand.
- S2 registers pos and found from S1. It also computes norm from S1 data:
  - found=1: norm = data << (WIDTH-1-pos), zero-filled.
  - found=0: norm = data, unshifted.
- Bubbles (invalid S1) propagate as invalid S2. Bubbles are not collapsed.
- Arithmetic: the shift amount is WIDTH-1-pos, which fits in POS_W bits. Bits shifted out of the MSB are discarded.

## Timing
- Latency: 2 cycles from the accepting edge to out_valid=1, when out_ready is held high.
- Throughput: 1 operand per cycle when out_ready is high.
- out_ready=0 with out_valid=1:
  - in_ready=0 in the same cycle.
  - All out_* hold stable until retired.
  - S1 contents are retained.
- out_valid=0: the pipe advances regardless of out_ready. An idle output never blocks input.
- Simultaneous accept and retire in one cycle are legal and lose no data.
- Reset (rst_n=0, at any time, including mid-stall) forces:
  - S1/S2 valid bits to 0.
  - out_valid=0, out_pos=0, out_found=0, out_norm=0.
  - in_ready=1 while reset is deasserted and out_valid=0.
- Reset does not wait for the handshake. In-flight operands are dropped.
- Edge cases:
  - Operand all-zero, or zero inside the window: found=0, pos=0.
  - Only bit WIDTH-1 set: pos=WIDTH-1, zero shift.
  - Only bit MIN_POS set: pos=MIN_POS.

## Configuration
- LOD_NORM_EN defined: the S2 shifter is built and out_norm behaves as in Operation.
- LOD_NORM_EN undefined:
  - The shifter and the S1 raw-data register are removed.
  - out_norm is tied to 0.
  - out_pos, out_found, the handshake and latency are unchanged.

## Test plan
WIDTH=16, MIN_POS=8, LOD_NORM_EN defined, unless noted.
- Directed values, out_ready=1. Each result must appear 2 cycles after acceptance:
  - 16'h8000 -> pos 15, found 1, norm 16'h8000.
  - 16'h0100 -> pos 8, found 1, norm 16'h8000.
  - 16'h0A30 -> pos 11, found 1, norm 16'hA300.
  - 16'h00FF -> pos 0, found 0, norm 16'h00FF.
  - 16'h0000 -> pos 0, found 0, norm 16'h0000.
- Streaming: 8 back-to-back operands with in_valid=1 and out_ready=1 -> 8 results on 8 consecutive cycles, in order, no gaps.
- Backpressure:
  - Stimulus: push 16'h4000 then 16'h0200, then hold out_ready=0 for 3 cycles.
  - Required: in_ready=0 for those 3 cycles, and out_pos stays 14 and stable.
  - Required after release: 14 then 9 retire on consecutive cycles, with no loss or duplication.
- Reset mid-stall: assert rst_n=0 asynchronously, between clock edges, while out_valid=1 -> out_valid, out_pos, out_found and out_norm go to 0 immediately; after release, the first new operand (16'h2000) yields pos 13 two cycles after acceptance.
- Parameter sweep, WIDTH=32, MIN_POS=0: operand 32'h0000_0001 -> pos 0, found 1, norm 32'h8000_0000.
- LOD_NORM_EN undefined, operand 16'h0A30 -> pos 11, found 1, out_norm 0, latency still 2.
